gcd_iter_ctrl: RTL and testbench

Sequential Euclid-by-subtraction engine that drives the team's combinational operand-swap stage, which sits directly downstream. Each iteration, this block presents the operand registers plus the Control/FlagZ qualifiers to the swap stage. It captures the reordered pair, subtracts, and repeats until the divisor is zero. It returns the GCD over a ready/start/done handshake.

---
 rtl/gcd_iter_ctrl_if.sv | 32 +++
 rtl/gcd_iter_ctrl.sv | 107 ++++++++++
 tb/tb_gcd_iter_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_iter_ctrl_if.sv
// Handshake and swap-stage bundle for the iterative GCD engine.
// slave = engine side, master = requester / swap-stage side.
interface gcd_iter_ctrl_if #(
    parameter int BW = 8
);
    logic          start;
    logic [BW-1:0] A_in;
    logic [BW-1:0] B_in;
    logic          ready;
    logic          done;
    logic [BW-1:0] result;
    logic          err;
    logic [BW:0]   iter_cnt;
    logic [BW-1:0] A;
    logic [BW-1:0] B;
    logic          Control;
    logic          FlagZ;
    logic [BW-1:0] RA;
    logic [BW-1:0] RB;

    modport slave (
        input  start, A_in, B_in, RA, RB,
        output ready, done, result, err, iter_cnt,
        output A, B, Control, FlagZ
    );

    modport master (
        output start, A_in, B_in, RA, RB,
        input  ready, done, result, err, iter_cnt,
        input  A, B, Control, FlagZ
    );
endinterface

// File: rtl/gcd_iter_ctrl.sv
// Euclid-by-subtraction GCD engine driving an external
// combinational operand-swap stage; ready/start/done handshake.
module gcd_iter_ctrl #(
    parameter int BW       = 8,
    parameter int MAX_ITER = 511
) (
    input logic          clk,
    input logic          rst_n,
    gcd_iter_ctrl_if.slave bus
);
    localparam logic [BW:0] MAX_CNT = (BW+1)'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SUB,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [BW-1:0] result_q, result_d;
    logic          err_q, err_d;
    logic [BW:0]   iter_cnt_q, iter_cnt_d;

    logic          flag_z;
    logic          ctrl;

    assign flag_z = (b_q == '0);
    assign ctrl   = (a_q >= b_q);

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.Control  = ctrl;
    assign bus.FlagZ    = flag_z;
    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.err      = err_q;
    assign bus.iter_cnt = iter_cnt_q;

    // State and datapath registers; reset aborts any job silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            err_q      <= err_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    // Next state: capture swapped pair in CHECK, subtract in SUB.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        err_d      = err_q;
        iter_cnt_d = iter_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d        = bus.A_in;
                    b_d        = bus.B_in;
                    iter_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (flag_z) begin
                    result_d = a_q;
                    state_d  = ST_DONE;
                end else if (iter_cnt_q == MAX_CNT) begin
                    result_d = a_q;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    a_d     = bus.RA;
                    b_d     = bus.RB;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                a_d        = a_q - b_q;
                iter_cnt_d = iter_cnt_q + (BW+1)'(1);
                state_d    = ST_CHECK;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_gcd_iter_ctrl.sv
// Bench for gcd_iter_ctrl: vector table plus scoreboard queue,
// with hand sequences for reset, swap, back-to-back and limit.
module tb_gcd_iter_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       spam;
        logic [7:0] res;
        int         n;
        logic       e;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        int         n;
        logic       e;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[6];

    gcd_iter_ctrl_if #(.BW(8)) if1 ();
    gcd_iter_ctrl_if #(.BW(8)) if2 ();

    gcd_iter_ctrl #(.BW(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    gcd_iter_ctrl #(.BW(8), .MAX_ITER(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    // Swap-stage models
    assign if1.RA = (~if1.FlagZ & ~if1.Control) ? if1.B : if1.A;
    assign if1.RB = (~if1.FlagZ & ~if1.Control) ? if1.A : if1.B;
    assign if2.RA = (~if2.FlagZ & ~if2.Control) ? if2.B : if2.A;
    assign if2.RB = (~if2.FlagZ & ~if2.Control) ? if2.A : if2.B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor for DUT1
    always begin
        exp_t ex;
        @(posedge clk);
        #1;
        if (if1.done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d result %0d",
                         cyc, if1.result);
            end else begin
                ex = sbq.pop_front();
                chk("result", int'(if1.result), int'(ex.res));
                chk("iter_cnt", int'(if1.iter_cnt), ex.n);
                chk("err", int'(if1.err), int'(ex.e));
                chk("latency", cyc - ex.acc + 1, 2 * ex.n + 2);
            end
        end
    end

    task automatic start_job(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] res, input int n,
                             input logic e);
        exp_t ex;
        int k;
        k = 0;
        while (!if1.ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!if1.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got 0 expected 1");
        end
        if1.start = 1'b1;
        if1.A_in  = a;
        if1.B_in  = b;
        @(posedge clk);
        #1;
        ex.res = res;
        ex.n   = n;
        ex.e   = e;
        ex.acc = cyc;
        sbq.push_back(ex);
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input logic spam);
        bit seen;
        seen = 1'b0;
        if1.start = spam;
        for (int k = 0; k < 1200 && !seen; k++) begin
            if (spam) begin
                if1.A_in = 8'($urandom);
                if1.B_in = 8'($urandom);
            end
            @(posedge clk);
            #1;
            if (if1.done) seen = 1'b1;
        end
        if1.start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got 0 expected 1");
            sbq.delete();
        end
    endtask

    initial begin
        int k0;
        bit seen;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if1.start = 1'b0;
        if1.A_in  = '0;
        if1.B_in  = '0;
        if2.start = 1'b0;
        if2.A_in  = '0;
        if2.B_in  = '0;

        tbl[0] = '{8'd12,  8'd8, 1'b0, 8'd4, 4,   1'b0};
        tbl[1] = '{8'd0,   8'd0, 1'b0, 8'd0, 0,   1'b0};
        tbl[2] = '{8'd0,   8'd5, 1'b0, 8'd5, 1,   1'b0};
        tbl[3] = '{8'd255, 8'd1, 1'b1, 8'd1, 256, 1'b0};
        tbl[4] = '{8'd7,   8'd7, 1'b0, 8'd7, 2,   1'b0};
        tbl[5] = '{8'd9,   8'd6, 1'b0, 8'd3, 4,   1'b0};

        // Reset with start toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if1.start = ~if1.start;
            if1.A_in  = 8'd77;
            if1.B_in  = 8'd11;
        end
        chk("rst_ready", int'(if1.ready), 1);
        chk("rst_done", int'(if1.done), 0);
        chk("rst_result", int'(if1.result), 0);
        chk("rst_err", int'(if1.err), 0);
        chk("rst_iter_cnt", int'(if1.iter_cnt), 0);
        if1.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Swap observed in CHECK at (4,8)
        start_job(8'd12, 8'd8, 8'd4, 4, 1'b0);
        chk("chk1_control", int'(if1.Control), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("swap_A", int'(if1.A), 4);
        chk("swap_B", int'(if1.B), 8);
        chk("swap_control", int'(if1.Control), 0);
        chk("swap_flagz", int'(if1.FlagZ), 0);
        wait_done(1'b0);

        // Table-driven jobs
        for (int i = 0; i < 6; i++) begin
            start_job(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].n, tbl[i].e);
            wait_done(tbl[i].spam);
        end

        // Back-to-back: start in the IDLE cycle right after done
        start_job(8'd40, 8'd25, 8'd5, 6, 1'b0);
        wait_done(1'b0);
        @(posedge clk);
        #1;
        chk("b2b_ready", int'(if1.ready), 1);
        chk("b2b_result_held", int'(if1.result), 5);
        start_job(8'd21, 8'd14, 8'd7, 4, 1'b0);
        wait_done(1'b0);

        // Reset mid-job: no done pulse afterwards
        start_job(8'd200, 8'd3, 8'd0, 0, 1'b0);
        void'(sbq.pop_back());
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midjob_busy", int'(if1.ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(if1.ready), 1);
        chk("midrst_result", int'(if1.result), 0);
        chk("midrst_iter_cnt", int'(if1.iter_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_idle", int'(if1.ready), 1);

        // Iteration limit on the MAX_ITER=4 instance
        if2.start = 1'b1;
        if2.A_in  = 8'd100;
        if2.B_in  = 8'd1;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        k0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (if2.done) seen = 1'b1;
        end
        chk("lim_done_seen", int'(seen), 1);
        chk("lim_result", int'(if2.result), 96);
        chk("lim_err", int'(if2.err), 1);
        chk("lim_iter_cnt", int'(if2.iter_cnt), 4);
        chk("lim_latency", cyc - k0 + 1, 10);
        @(posedge clk);
        #1;
        chk("lim_err_held", int'(if2.err), 1);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover got %0d expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
